lstm_seq_driver: RTL and testbench
==================================

Name: lstm_seq_driver

Overview:
Synthesisable, parametrised sequencer for the LSTM core's init and next-data ports: init/stimulus loading becomes an on-chip block. On start it streams weight, bias and context bytes from a byte-wide parameter memory into the core. It then feeds NUM_SAMPLES input vectors, captures each H_t, checks it against golden bytes, and reports pass/fail, mismatch count and the index of each failing sample.

Parameters:
X_SIZE, 8, input vector bytes per sample
H_SIZE, 8, output vector bytes per sample
W_SIZE, 512, weight bytes
B_SIZE, 32, bias bytes
CTX_SIZE, 16, initial-context bytes
NUM_SAMPLES, 10, samples per run
ADDR_W, 16, memory address width
TIMEOUT_CYC, 4096, watchdog limit (SEQ_TIMEOUT_EN only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle run request
busy  out  1  run in progress
done  out  1  run finished; held until next accepted start
pass  out  1  valid while done: err_count==0 and no timeout
err_count  out  16  mismatching samples, saturates at 0xFFFF
mis_valid  out  1  one-cycle pulse per mismatching sample
mis_index  out  16  sample index of last mismatch
timeout  out  1  watchdog fired (tied 0 without macro)
mem_req  out  1  one-cycle read request
mem_sel  out  3  region: 0 weight, 1 bias, 2 context, 3 input, 4 expected
mem_addr  out  ADDR_W  byte address within region
mem_rdata  in  8  returned byte
mem_rvalid  in  1  rdata valid, latency >=1 cycle
init_valid  out  1  init byte strobe
init_type  out  3  0 weight, 1 bias, 2 context, 7 idle
init_data  out  8  init byte
next_valid  out  1  one-cycle input strobe
next_data  out  X_SIZE*8  packed input vector
lstm_done  in  1  core idle/result ready
lstm_ht  in  H_SIZE*8  core H_t

Behaviour:
- Reset: all outputs 0 except init_type=7; FSM to IDLE; counters cleared. rst mid-run aborts immediately, no further requests or strobes.
- One outstanding memory request: mem_req only when none pending; rvalid with none pending is ignored.
- FSM: IDLE -> LOAD_W -> LOAD_B -> LOAD_CTX -> per sample: FETCH_X -> WAIT_RDY -> ISSUE -> WAIT_BUSY -> WAIT_RES -> FETCH_EXP -> CHECK -> next sample, or FINISH after NUM_SAMPLES.
- IDLE: start accepted -> busy=1, done=0, err_count=0, timeout=0. start while busy ignored.
- LOAD_*: addresses 0..SIZE-1 of the region. Each rvalid -> next cycle init_valid=1, init_data=rdata, init_type=phase code. init_type=7 outside LOAD_*.
- FETCH_X: addresses s*X_SIZE .. s*X_SIZE+X_SIZE-1, region 3. Bytes shift in MSB-first: the first byte ends in next_data[X_SIZE*8-1 -: 8].
- WAIT_RDY: wait lstm_done=1. ISSUE: next_valid=1 for exactly one cycle. next_data is held until the next ISSUE.
- WAIT_BUSY: wait lstm_done=0. WAIT_RES: on first cycle lstm_done=1, register lstm_ht.
- FETCH_EXP: region 4, same addressing/packing with H_SIZE.
- CHECK (1 cycle): on mismatch, mis_valid=1, mis_index=s, err_count+1 (saturating).
- FINISH: busy=0, done=1, pass=(err_count==0 && !timeout); return to IDLE. A start in the FINISH cycle is ignored.
- Sample counter 16 bit; NUM_SAMPLES=0 goes from LOAD_CTX directly to FINISH.

Optional Feature:
SEQ_TIMEOUT_EN:
- Defined: a watchdog counts cycles spent in WAIT_RDY, WAIT_BUSY or WAIT_RES, or with a memory request pending. It clears on every state change and on every rvalid.
- When the count reaches TIMEOUT_CYC: timeout=1, go to FINISH with pass=0; any pending rvalid is then ignored.
- Not defined: no counter; waits are unbounded; timeout tied 0.

Test Plan:
- Load only: NUM_SAMPLES=0, memory latency 1, weight byte = addr[7:0] -> 512 init_valid pulses type 0 data 0..255,0..255, then 32 type 1, 16 type 2, done=1, pass=1.
- Golden run: core model returns H = X XOR 0x5A per byte, expected region matches, 10 samples -> 10 next_valid pulses, err_count=0, pass=1. First next_data = bytes 0..7 packed MSB-first.
- Mismatch: corrupt expected byte 3 of sample 4 -> single mis_valid, mis_index=4, err_count=1, pass=0.
- Handshake: lstm_done held low 20 cycles after power-up -> no next_valid until done rises. Random memory latency 1..7 -> identical init byte stream.
- Reset mid-run: rst during LOAD_B byte 10 -> next cycle all outputs 0, init_type=7. A new start reloads from weight byte 0.
- Timeout (macro on, TIMEOUT_CYC=64): lstm_done never falls after ISSUE -> timeout=1 exactly 64 cycles later, done=1, pass=0. Macro off -> busy stays 1.

Source files
------------

// File: rtl/lstm_seq_driver.sv
// lstm_seq_driver: streams LSTM weights/bias/context and input vectors from a byte memory and checks H_t.
// Optional stall watchdog compiled in with `define SEQ_TIMEOUT_EN.
module lstm_seq_driver #(
    parameter int X_SIZE      = 8,
    parameter int H_SIZE      = 8,
    parameter int W_SIZE      = 512,
    parameter int B_SIZE      = 32,
    parameter int CTX_SIZE    = 16,
    parameter int NUM_SAMPLES = 10,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic                mis_valid,
    output logic [15:0]         mis_index,
    output logic                timeout,
    output logic                mem_req,
    output logic [2:0]          mem_sel,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [7:0]          mem_rdata,
    input  logic                mem_rvalid,
    output logic                init_valid,
    output logic [2:0]          init_type,
    output logic [7:0]          init_data,
    output logic                next_valid,
    output logic [X_SIZE*8-1:0] next_data,
    input  logic                lstm_done,
    input  logic [H_SIZE*8-1:0] lstm_ht
);
    localparam int XW = X_SIZE * 8;
    localparam int HW = H_SIZE * 8;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_W, S_LOAD_B, S_LOAD_CTX, S_FETCH_X, S_WAIT_RDY,
        S_ISSUE, S_WAIT_BUSY, S_WAIT_RES, S_FETCH_EXP, S_CHECK, S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d, smp_q, smp_d;
    logic [15:0]   err_q, err_d, misi_q, misi_d;
    logic          pend_q, pend_d, busy_q, busy_d, done_q, done_d;
    logic          pass_q, pass_d, misv_q, misv_d, to_q, to_d;
    logic          iv_q, iv_d;
    logic [2:0]    it_q, it_d;
    logic [7:0]    idat_q, idat_d;
    logic [XW-1:0] xbuf_q, xbuf_d, nd_q, nd_d;
    logic [HW-1:0] ht_q, ht_d, exp_q, exp_d;

    logic          is_load, is_fetch, rx, last;
    logic [15:0]   size;
    logic [31:0]   base;
    logic [2:0]    sel;
`ifdef SEQ_TIMEOUT_EN
    logic [31:0]   wd_q, wd_d;
    logic          wd_run;
`endif

    // Region decode for the current fetch phase
    always_comb begin
        is_load  = 1'b0;
        is_fetch = 1'b0;
        sel      = 3'd0;
        size     = 16'd0;
        base     = 32'd0;
        unique case (state_q)
            S_LOAD_W:    begin is_load = 1'b1; is_fetch = 1'b1; sel = 3'd0; size = 16'(W_SIZE); end
            S_LOAD_B:    begin is_load = 1'b1; is_fetch = 1'b1; sel = 3'd1; size = 16'(B_SIZE); end
            S_LOAD_CTX:  begin is_load = 1'b1; is_fetch = 1'b1; sel = 3'd2; size = 16'(CTX_SIZE); end
            S_FETCH_X: begin
                is_fetch = 1'b1;
                sel      = 3'd3;
                size     = 16'(X_SIZE);
                base     = 32'(smp_q) * 32'(X_SIZE);
            end
            S_FETCH_EXP: begin
                is_fetch = 1'b1;
                sel      = 3'd4;
                size     = 16'(H_SIZE);
                base     = 32'(smp_q) * 32'(H_SIZE);
            end
            default: ;
        endcase
    end

    assign rx       = pend_q & mem_rvalid;
    assign last     = rx && (cnt_q == size - 16'd1);
    assign mem_req  = is_fetch & ~pend_q;
    assign mem_sel  = sel;
    assign mem_addr = ADDR_W'(base + 32'(cnt_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        smp_d   = smp_q;
        err_d   = err_q;
        misi_d  = misi_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        misv_d  = 1'b0;
        to_d    = to_q;
        iv_d    = is_load & rx;
        it_d    = is_load ? sel : 3'd7;
        idat_d  = (is_load && rx) ? mem_rdata : idat_q;
        xbuf_d  = xbuf_q;
        nd_d    = nd_q;
        ht_d    = ht_q;
        exp_d   = exp_q;
        if (rx) cnt_d = last ? 16'd0 : cnt_q + 16'd1;
        if (mem_req) pend_d = 1'b1;
        else if (rx) pend_d = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d = S_LOAD_W;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                pass_d  = 1'b0;
                err_d   = 16'd0;
                to_d    = 1'b0;
                smp_d   = 16'd0;
                cnt_d   = 16'd0;
            end
            S_LOAD_W:   if (last) state_d = S_LOAD_B;
            S_LOAD_B:   if (last) state_d = S_LOAD_CTX;
            S_LOAD_CTX: if (last) state_d = (NUM_SAMPLES == 0) ? S_FINISH : S_FETCH_X;
            S_FETCH_X: begin
                if (rx) xbuf_d = XW'({xbuf_q, mem_rdata});
                if (last) state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: if (lstm_done) begin
                nd_d    = xbuf_q;
                state_d = S_ISSUE;
            end
            S_ISSUE:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!lstm_done) state_d = S_WAIT_RES;
            S_WAIT_RES: if (lstm_done) begin
                ht_d    = lstm_ht;
                state_d = S_FETCH_EXP;
            end
            S_FETCH_EXP: begin
                if (rx) exp_d = HW'({exp_q, mem_rdata});
                if (last) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (ht_q != exp_q) begin
                    misv_d = 1'b1;
                    misi_d = smp_q;
                    if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                end
                smp_d   = smp_q + 16'd1;
                state_d = ({1'b0, smp_q} + 17'd1 >= 17'(NUM_SAMPLES)) ? S_FINISH : S_FETCH_X;
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_q == 16'd0) && !to_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef SEQ_TIMEOUT_EN
        // Counts only while stalled; any progress restarts it
        wd_run = pend_q || (state_q inside {S_WAIT_RDY, S_WAIT_BUSY, S_WAIT_RES});
        wd_d   = 32'd0;
        if (wd_run && !rx && state_d == state_q) begin
            wd_d = wd_q + 32'd1;
            if (wd_d >= 32'(TIMEOUT_CYC)) begin
                wd_d    = 32'd0;
                state_d = S_FINISH;
                to_d    = 1'b1;
                pend_d  = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            smp_q   <= '0;
            err_q   <= '0;
            misi_q  <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            misv_q  <= 1'b0;
            to_q    <= 1'b0;
            iv_q    <= 1'b0;
            it_q    <= 3'd7;
            idat_q  <= '0;
            xbuf_q  <= '0;
            nd_q    <= '0;
            ht_q    <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            smp_q   <= smp_d;
            err_q   <= err_d;
            misi_q  <= misi_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            misv_q  <= misv_d;
            to_q    <= to_d;
            iv_q    <= iv_d;
            it_q    <= it_d;
            idat_q  <= idat_d;
            xbuf_q  <= xbuf_d;
            nd_q    <= nd_d;
            ht_q    <= ht_d;
            exp_q   <= exp_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign mis_valid  = misv_q;
    assign mis_index  = misi_q;
    assign timeout    = to_q;
    assign init_valid = iv_q;
    assign init_type  = it_q;
    assign init_data  = idat_q;
    assign next_valid = (state_q == S_ISSUE);
    assign next_data  = nd_q;
endmodule

// File: tb/tb_lstm_seq_driver.sv
// tb_lstm_seq_driver: random-latency memory, XOR-0x5A core model and
// a stream-level reference of the expected init/next/mismatch sequences.
module tb_lstm_seq_driver;
    localparam int XS = 8;
    localparam int HS = 8;
    localparam int WS = 512;
    localparam int BS = 32;
    localparam int CS = 16;
    localparam int NS = 10;
    localparam int AW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass, mis_valid, timeout;
    logic [15:0]   err_count, mis_index;
    logic          mem_req;
    logic [2:0]    mem_sel;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic          mem_rvalid;
    logic          init_valid;
    logic [2:0]    init_type;
    logic [7:0]    init_data;
    logic          next_valid;
    logic [XS*8-1:0] next_data;
    logic          lstm_done;
    logic [HS*8-1:0] lstm_ht;

    always #5 clk = ~clk;

    lstm_seq_driver #(
        .X_SIZE(XS), .H_SIZE(HS), .W_SIZE(WS), .B_SIZE(BS), .CTX_SIZE(CS),
        .NUM_SAMPLES(NS), .ADDR_W(AW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .mis_valid(mis_valid),
        .mis_index(mis_index), .timeout(timeout), .mem_req(mem_req),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .init_valid(init_valid),
        .init_type(init_type), .init_data(init_data),
        .next_valid(next_valid), .next_data(next_data),
        .lstm_done(lstm_done), .lstm_ht(lstm_ht)
    );

    logic [7:0] wmem [WS];
    logic [7:0] bmem [BS];
    logic [7:0] cmem [CS];
    logic [7:0] xmem [NS*XS];
    logic [7:0] emem [NS*HS];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int max_lat = 1;
    int rdy_at = 1500;
    int rdy_cyc = 0;
    bit hang = 0;
    int first_nv_cyc = 0;

    logic [10:0]     got_init [$];
    logic [XS*8-1:0] got_next [$];
    logic [15:0]     got_mis  [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd(input logic [2:0] s, input logic [AW-1:0] a);
        int i;
        i = int'(a);
        case (s)
            3'd0: return (i < WS) ? wmem[i] : 8'hEE;
            3'd1: return (i < BS) ? bmem[i] : 8'hEE;
            3'd2: return (i < CS) ? cmem[i] : 8'hEE;
            3'd3: return (i < NS*XS) ? xmem[i] : 8'hEE;
            3'd4: return (i < NS*HS) ? emem[i] : 8'hEE;
            default: return 8'hEE;
        endcase
    endfunction

    function automatic logic [XS*8-1:0] xvec(input int s);
        logic [XS*8-1:0] v;
        v = '0;
        for (int b = 0; b < XS; b++) v[(XS-1-b)*8 +: 8] = xmem[s*XS+b];
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Byte memory: one request at a time, latency 1..max_lat
    initial begin
        int lat;
        bit pend;
        logic [7:0] d;
        lat = 0;
        pend = 0;
        d = 8'h00;
        mem_rvalid = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (rst) pend = 0;
            else if (pend) begin
                lat--;
                if (lat == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = d;
                    pend = 0;
                end
            end else if (mem_req) begin
                d = rd(mem_sel, mem_addr);
                lat = $urandom_range(max_lat, 1);
                pend = 1;
            end
        end
    end

    // LSTM core: H = X ^ 0x5A after a random busy period
    initial begin
        logic [XS*8-1:0] v;
        lstm_done = 1'b0;
        lstm_ht = '0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc >= rdy_at) break;
        end
        lstm_done = 1'b1;
        rdy_cyc = cyc;
        forever begin
            @(negedge clk);
            if (next_valid && !hang) begin
                v = next_data;
                @(posedge clk);
                #1;
                repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
                lstm_done = 1'b0;
                repeat ($urandom_range(5, 1)) begin @(posedge clk); #1; end
                for (int b = 0; b < HS; b++) lstm_ht[b*8 +: 8] = v[b*8 +: 8] ^ 8'h5A;
                lstm_done = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (init_valid) got_init.push_back({init_type, init_data});
        if (next_valid) begin
            if (got_next.size() == 0) first_nv_cyc = cyc;
            got_next.push_back(next_data);
        end
        if (mis_valid) got_mis.push_back(mis_index);
    end

    task automatic fill(input bit ramp);
        foreach (wmem[i]) wmem[i] = ramp ? 8'(i) : 8'($urandom);
        foreach (bmem[i]) bmem[i] = 8'($urandom);
        foreach (cmem[i]) cmem[i] = 8'($urandom);
        foreach (xmem[i]) xmem[i] = 8'($urandom);
        foreach (emem[i]) emem[i] = xmem[i] ^ 8'h5A;
    endtask

    task automatic clear_q();
        got_init.delete();
        got_next.delete();
        got_mis.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_and_check(input string nm, input bit dup);
        logic [10:0] exp_init [$];
        logic [15:0] exp_mis [$];
        int to;
        int n;
        bit bad;
        foreach (wmem[i]) exp_init.push_back({3'd0, wmem[i]});
        foreach (bmem[i]) exp_init.push_back({3'd1, bmem[i]});
        foreach (cmem[i]) exp_init.push_back({3'd2, cmem[i]});
        for (int s = 0; s < NS; s++) begin
            bad = 0;
            for (int b = 0; b < HS; b++)
                if (emem[s*HS+b] != (xmem[s*XS+b] ^ 8'h5A)) bad = 1;
            if (bad) exp_mis.push_back(16'(s));
        end
        clear_q();
        pulse_start();
        check({nm, " busy_after_start"}, 64'(busy), 64'(1));
        check({nm, " done_cleared"}, 64'(done), 64'(0));
        to = 0;
        while (!done && to < 20000) begin
            start = (dup && to == 100) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            to++;
        end
        start = 1'b0;
        check({nm, " done"}, 64'(done), 64'(1));
        check({nm, " busy_end"}, 64'(busy), 64'(0));
        check({nm, " init_len"}, 64'(got_init.size()), 64'(exp_init.size()));
        n = (got_init.size() < exp_init.size()) ? got_init.size() : exp_init.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s init[%0d]", nm, i), 64'(got_init[i]), 64'(exp_init[i]));
        check({nm, " next_len"}, 64'(got_next.size()), 64'(NS));
        for (int i = 0; i < got_next.size() && i < NS; i++)
            check($sformatf("%s next[%0d]", nm, i), 64'(got_next[i]), 64'(xvec(i)));
        check({nm, " mis_len"}, 64'(got_mis.size()), 64'(exp_mis.size()));
        for (int i = 0; i < got_mis.size() && i < exp_mis.size(); i++)
            check($sformatf("%s mis[%0d]", nm, i), 64'(got_mis[i]), 64'(exp_mis[i]));
        check({nm, " err_count"}, 64'(err_count), 64'(exp_mis.size()));
        if (exp_mis.size() > 0)
            check({nm, " mis_index"}, 64'(mis_index), 64'(exp_mis[exp_mis.size()-1]));
        check({nm, " pass"}, 64'(pass), 64'(exp_mis.size() == 0));
        check({nm, " timeout"}, 64'(timeout), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        check({nm, " done_held"}, 64'(done), 64'(1));
    endtask

    initial begin
        int to;
        int nb;
        fill(1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst init_type", 64'(init_type), 64'(7));
        check("rst mem_req", 64'(mem_req), 64'(0));
        check("rst next_valid", 64'(next_valid), 64'(0));
        check("rst err_count", 64'(err_count), 64'(0));
        rst = 1'b0;

        // Golden run, latency 1, core not ready until well after load
        max_lat = 1;
        run_and_check("golden", 0);
        check("handshake order", 64'(first_nv_cyc > rdy_cyc), 64'(1));

        // Single corrupted byte, random latency
        fill(0);
        max_lat = 7;
        emem[4*HS+3] = emem[4*HS+3] ^ 8'(1 << $urandom_range(7, 0));
        run_and_check("mis4", 0);

        // Random corruption plus a start while busy
        fill(0);
        for (int s = 0; s < NS; s++)
            if ($urandom_range(2, 0) == 0)
                emem[s*HS + $urandom_range(HS-1, 0)] ^= 8'(1 + $urandom_range(254, 0));
        run_and_check("rand", 1);

        // Reset during LOAD_B byte 10
        fill(0);
        max_lat = 3;
        clear_q();
        pulse_start();
        to = 0;
        nb = 0;
        while (nb < 10 && to < 20000) begin
            @(posedge clk);
            #1;
            to++;
            nb = 0;
            foreach (got_init[i]) if (got_init[i][10:8] == 3'd1) nb++;
        end
        check("mid reached", 64'(nb), 64'(10));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid busy", 64'(busy), 64'(0));
        check("mid done", 64'(done), 64'(0));
        check("mid pass", 64'(pass), 64'(0));
        check("mid err_count", 64'(err_count), 64'(0));
        check("mid mis_valid", 64'(mis_valid), 64'(0));
        check("mid mis_index", 64'(mis_index), 64'(0));
        check("mid timeout", 64'(timeout), 64'(0));
        check("mid mem_req", 64'(mem_req), 64'(0));
        check("mid mem_sel", 64'(mem_sel), 64'(0));
        check("mid mem_addr", 64'(mem_addr), 64'(0));
        check("mid init_valid", 64'(init_valid), 64'(0));
        check("mid init_type", 64'(init_type), 64'(7));
        check("mid init_data", 64'(init_data), 64'(0));
        check("mid next_valid", 64'(next_valid), 64'(0));
        check("mid next_data", 64'(next_data), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_and_check("rerun", 0);

        // Core never drops lstm_done after ISSUE
        fill(0);
        max_lat = 2;
        hang = 1;
        clear_q();
        pulse_start();
        to = 0;
        while (got_next.size() == 0 && to < 20000) begin
            @(posedge clk);
            #1;
            to++;
        end
        check("hang issued", 64'(got_next.size()), 64'(1));
`ifdef SEQ_TIMEOUT_EN
        to = 0;
        while (!timeout && to < TO + 20) begin
            @(negedge clk);
            to++;
        end
        check("to delay", 64'(cyc - first_nv_cyc), 64'(TO + 1));
        to = 0;
        while (!done && to < 20) begin
            @(posedge clk);
            #1;
            to++;
        end
        check("to done", 64'(done), 64'(1));
        check("to pass", 64'(pass), 64'(0));
        check("to flag", 64'(timeout), 64'(1));
`else
        repeat (200) @(posedge clk);
        #1;
        check("hang busy", 64'(busy), 64'(1));
        check("hang timeout", 64'(timeout), 64'(0));
        check("hang done", 64'(done), 64'(0));
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hang = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
